axi_error_responder: RTL and testbench

// - AXI4+ATOP terminating responder (slave end of AXI_BUS): accepts every request and answers with
//   a fixed error response.
// - Sits behind a crossbar/demux default port or address-modifier output for unmapped ranges, so

---
 rtl/axi_error_responder_pkg.sv | 26 ++
 rtl/axi_error_rd_burst.sv | 95 +++++++++
 rtl/axi_error_responder.sv | 188 ++++++++++++++++++
 tb/tb_axi_error_responder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_error_responder_pkg.sv
// Shared types and constants for the AXI error responder: response codes, beat-length
// type, the atop bit that asks for a read response, and the write/read FSM encodings.
package axi_error_responder_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int unsigned ATOP_R_RESP = 5;

   typedef logic [7:0] len_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_ATOP,
      W_RESP
   } w_state_e;

   typedef enum logic {
      R_IDLE,
      R_SEND
   } r_state_e;

endpackage

// File: rtl/axi_error_rd_burst.sv
// Read-burst engine: loads id/len from a request, then drives len+1 error R beats; request
// accepted @N gives r_valid @N+1. R payload stays frozen while r_valid && !r_ready.
module axi_error_rd_burst
   import axi_error_responder_pkg::*;
#(
   parameter int unsigned           ID_WIDTH   = 4,
   parameter int unsigned           DATA_WIDTH = 64,
   parameter logic [1:0]            RESP       = RESP_DECERR,
   parameter logic [DATA_WIDTH-1:0] DATA       = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_vld_i,
   output logic                  req_rdy_o,
   input  logic [ID_WIDTH-1:0]   req_id_i,
   input  len_t                  req_len_i,
   input  logic                  req_atop_i,
   output logic                  done_o,
   output logic [ID_WIDTH-1:0]   r_id_o,
   output logic [DATA_WIDTH-1:0] r_data_o,
   output logic [1:0]            r_resp_o,
   output logic                  r_last_o,
   output logic                  r_valid_o,
   input  logic                  r_ready_i
);

   r_state_e            state_q, state_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   len_t                len_q, len_d;
   len_t                cnt_q, cnt_d;
   logic                atop_q, atop_d;
   logic                last_beat;

   // cnt never passes len, so len=255 yields 256 beats without wrapping.
   assign last_beat = (cnt_q == len_q);
   assign r_id_o    = id_q;

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      atop_d    = atop_q;
      req_rdy_o = 1'b0;
      done_o    = 1'b0;
      r_valid_o = 1'b0;
      r_last_o  = 1'b0;
      r_data_o  = '0;
      r_resp_o  = RESP_OKAY;
      case (state_q)
         R_IDLE: begin
            req_rdy_o = 1'b1;
            if (req_vld_i) begin
               id_d    = req_id_i;
               len_d   = req_len_i;
               atop_d  = req_atop_i;
               cnt_d   = '0;
               state_d = R_SEND;
            end
         end
         R_SEND: begin
            r_valid_o = 1'b1;
            r_data_o  = DATA;
            r_resp_o  = RESP;
            r_last_o  = last_beat;
            if (r_ready_i) begin
               if (last_beat) begin
                  state_d = R_IDLE;
                  done_o  = atop_q;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= R_IDLE;
         id_q    <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         atop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         atop_q  <= atop_d;
      end
   end

endmodule

// File: rtl/axi_error_responder.sv
// Terminating AXI4+ATOP slave answering every request with RESP; AW->w_ready and w_last->B
// take one cycle, AR->first R one cycle. B and R hold stable until ready; one write in flight.
module axi_error_responder
   import axi_error_responder_pkg::*;
#(
   parameter int unsigned AXI_ID_WIDTH   = 4,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_USER_WIDTH = 1,
   parameter logic [1:0]  RESP           = RESP_DECERR,
   parameter logic [63:0] RESP_DATA      = 64'hCA11_AB1E_BAD_CAB1E,
   parameter bit          ATOPS          = 1'b1
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [AXI_ID_WIDTH-1:0]     slv_aw_id,
   input  logic [AXI_ADDR_WIDTH-1:0]   slv_aw_addr,
   input  logic [7:0]                  slv_aw_len,
   input  logic [2:0]                  slv_aw_size,
   input  logic [1:0]                  slv_aw_burst,
   input  logic                        slv_aw_lock,
   input  logic [3:0]                  slv_aw_cache,
   input  logic [2:0]                  slv_aw_prot,
   input  logic [3:0]                  slv_aw_qos,
   input  logic [3:0]                  slv_aw_region,
   input  logic [5:0]                  slv_aw_atop,
   input  logic [AXI_USER_WIDTH-1:0]   slv_aw_user,
   input  logic                        slv_aw_valid,
   output logic                        slv_aw_ready,
   input  logic [AXI_DATA_WIDTH-1:0]   slv_w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] slv_w_strb,
   input  logic                        slv_w_last,
   input  logic [AXI_USER_WIDTH-1:0]   slv_w_user,
   input  logic                        slv_w_valid,
   output logic                        slv_w_ready,
   output logic [AXI_ID_WIDTH-1:0]     slv_b_id,
   output logic [1:0]                  slv_b_resp,
   output logic [AXI_USER_WIDTH-1:0]   slv_b_user,
   output logic                        slv_b_valid,
   input  logic                        slv_b_ready,
   input  logic [AXI_ID_WIDTH-1:0]     slv_ar_id,
   input  logic [AXI_ADDR_WIDTH-1:0]   slv_ar_addr,
   input  logic [7:0]                  slv_ar_len,
   input  logic [2:0]                  slv_ar_size,
   input  logic [1:0]                  slv_ar_burst,
   input  logic                        slv_ar_lock,
   input  logic [3:0]                  slv_ar_cache,
   input  logic [2:0]                  slv_ar_prot,
   input  logic [3:0]                  slv_ar_qos,
   input  logic [3:0]                  slv_ar_region,
   input  logic [AXI_USER_WIDTH-1:0]   slv_ar_user,
   input  logic                        slv_ar_valid,
   output logic                        slv_ar_ready,
   output logic [AXI_ID_WIDTH-1:0]     slv_r_id,
   output logic [AXI_DATA_WIDTH-1:0]   slv_r_data,
   output logic [1:0]                  slv_r_resp,
   output logic                        slv_r_last,
   output logic [AXI_USER_WIDTH-1:0]   slv_r_user,
   output logic                        slv_r_valid,
   input  logic                        slv_r_ready
);

   function automatic logic [AXI_DATA_WIDTH-1:0] fill_pattern();
      logic [AXI_DATA_WIDTH+63:0] acc;
      acc = '0;
      for (int i = 0; i < (AXI_DATA_WIDTH + 63) / 64; i++) begin
         acc = {acc[AXI_DATA_WIDTH-1:0], RESP_DATA};
      end
      return acc[AXI_DATA_WIDTH-1:0];
   endfunction

   localparam logic [AXI_DATA_WIDTH-1:0] RespDataFill = fill_pattern();

   w_state_e                w_state_q, w_state_d;
   logic [AXI_ID_WIDTH-1:0] id_q, id_d;
   len_t                    len_q, len_d;
   logic                    atop_q, atop_d;
   logic                    taken_q, taken_d;
   logic                    atop_pending;
   logic                    rd_req_vld;
   logic                    rd_req_rdy;
   logic [AXI_ID_WIDTH-1:0] rd_req_id;
   len_t                    rd_req_len;
   logic                    rd_done;

   // An atomic waiting in W_ATOP wins the read engine over any AR in the same cycle.
   assign atop_pending = (w_state_q == W_ATOP) && !taken_q;
   assign rd_req_vld   = !rst_i && (atop_pending || slv_ar_valid);
   assign rd_req_id    = atop_pending ? id_q : slv_ar_id;
   assign rd_req_len   = atop_pending ? len_q : slv_ar_len;
   assign slv_ar_ready = rd_req_rdy && !atop_pending && !rst_i;

   assign slv_b_id   = id_q;
   assign slv_b_resp = RESP;
   assign slv_b_user = '0;
   assign slv_r_user = '0;

   always_comb begin
      w_state_d    = w_state_q;
      id_d         = id_q;
      len_d        = len_q;
      atop_d       = atop_q;
      taken_d      = taken_q;
      slv_aw_ready = 1'b0;
      slv_w_ready  = 1'b0;
      slv_b_valid  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            slv_aw_ready = !rst_i;
            if (slv_aw_valid && !rst_i) begin
               id_d      = slv_aw_id;
               len_d     = slv_aw_len;
               atop_d    = ATOPS && slv_aw_atop[ATOP_R_RESP];
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            slv_w_ready = 1'b1;
            if (slv_w_valid && slv_w_last) begin
               w_state_d = atop_q ? W_ATOP : W_RESP;
            end
         end
         W_ATOP: begin
            if (atop_pending && rd_req_rdy) begin
               taken_d = 1'b1;
            end
            if (rd_done) begin
               taken_d   = 1'b0;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            slv_b_valid = 1'b1;
            if (slv_b_ready) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state_q <= W_IDLE;
         id_q      <= '0;
         len_q     <= '0;
         atop_q    <= 1'b0;
         taken_q   <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         id_q      <= id_d;
         len_q     <= len_d;
         atop_q    <= atop_d;
         taken_q   <= taken_d;
      end
   end

   axi_error_rd_burst #(
      .ID_WIDTH   (AXI_ID_WIDTH),
      .DATA_WIDTH (AXI_DATA_WIDTH),
      .RESP       (RESP),
      .DATA       (RespDataFill)
   ) u_rd_burst (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .req_vld_i  (rd_req_vld),
      .req_rdy_o  (rd_req_rdy),
      .req_id_i   (rd_req_id),
      .req_len_i  (rd_req_len),
      .req_atop_i (atop_pending),
      .done_o     (rd_done),
      .r_id_o     (slv_r_id),
      .r_data_o   (slv_r_data),
      .r_resp_o   (slv_r_resp),
      .r_last_o   (slv_r_last),
      .r_valid_o  (slv_r_valid),
      .r_ready_i  (slv_r_ready)
   );

   // Address, attributes, write payload and user inputs carry no meaning for an error sink.
   logic unused_inputs;
   assign unused_inputs = ^{slv_aw_addr, slv_aw_size, slv_aw_burst, slv_aw_lock, slv_aw_cache,
                            slv_aw_prot, slv_aw_qos, slv_aw_region, slv_aw_atop, slv_aw_user,
                            slv_w_data, slv_w_strb, slv_w_user, slv_ar_addr, slv_ar_size,
                            slv_ar_burst, slv_ar_lock, slv_ar_cache, slv_ar_prot, slv_ar_qos,
                            slv_ar_region, slv_ar_user};

endmodule

// File: tb/tb_axi_error_responder.sv
// Directed plus randomized bench for axi_error_responder against a queue-based transaction model.
module tb_axi_error_responder;

   localparam logic [63:0] PAT = 64'hCA11_AB1E_BAD_CAB1E;
   localparam int          N   = 500;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  aw_id;  logic [31:0] aw_addr; logic [7:0] aw_len; logic [2:0] aw_size;
   logic [1:0]  aw_burst; logic aw_lock; logic [3:0] aw_cache; logic [2:0] aw_prot;
   logic [3:0]  aw_qos; logic [3:0] aw_region; logic [5:0] aw_atop; logic [0:0] aw_user;
   logic        aw_valid, aw_ready;
   logic [63:0] w_data; logic [7:0] w_strb; logic w_last; logic [0:0] w_user;
   logic        w_valid, w_ready;
   logic [3:0]  b_id; logic [1:0] b_resp; logic [0:0] b_user; logic b_valid, b_ready;
   logic [3:0]  ar_id;  logic [31:0] ar_addr; logic [7:0] ar_len; logic [2:0] ar_size;
   logic [1:0]  ar_burst; logic ar_lock; logic [3:0] ar_cache; logic [2:0] ar_prot;
   logic [3:0]  ar_qos; logic [3:0] ar_region; logic [0:0] ar_user;
   logic        ar_valid, ar_ready;
   logic [3:0]  r_id; logic [63:0] r_data; logic [1:0] r_resp; logic r_last; logic [0:0] r_user;
   logic        r_valid, r_ready;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axi_error_responder dut (
      .clk_i(clk), .rst_i(rst),
      .slv_aw_id(aw_id), .slv_aw_addr(aw_addr), .slv_aw_len(aw_len), .slv_aw_size(aw_size),
      .slv_aw_burst(aw_burst), .slv_aw_lock(aw_lock), .slv_aw_cache(aw_cache),
      .slv_aw_prot(aw_prot), .slv_aw_qos(aw_qos), .slv_aw_region(aw_region),
      .slv_aw_atop(aw_atop), .slv_aw_user(aw_user), .slv_aw_valid(aw_valid),
      .slv_aw_ready(aw_ready),
      .slv_w_data(w_data), .slv_w_strb(w_strb), .slv_w_last(w_last), .slv_w_user(w_user),
      .slv_w_valid(w_valid), .slv_w_ready(w_ready),
      .slv_b_id(b_id), .slv_b_resp(b_resp), .slv_b_user(b_user), .slv_b_valid(b_valid),
      .slv_b_ready(b_ready),
      .slv_ar_id(ar_id), .slv_ar_addr(ar_addr), .slv_ar_len(ar_len), .slv_ar_size(ar_size),
      .slv_ar_burst(ar_burst), .slv_ar_lock(ar_lock), .slv_ar_cache(ar_cache),
      .slv_ar_prot(ar_prot), .slv_ar_qos(ar_qos), .slv_ar_region(ar_region),
      .slv_ar_user(ar_user), .slv_ar_valid(ar_valid), .slv_ar_ready(ar_ready),
      .slv_r_id(r_id), .slv_r_data(r_data), .slv_r_resp(r_resp), .slv_r_last(r_last),
      .slv_r_user(r_user), .slv_r_valid(r_valid), .slv_r_ready(r_ready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [7:0] len, input logic [5:0] atop);
      int k = 0;
      @(negedge clk); aw_id = id; aw_len = len; aw_atop = atop; aw_valid = 1'b1; #1;
      while (!aw_ready && k < 100) begin @(negedge clk); #1; k++; end
      chk("aw_accept", aw_ready, 1);
      @(negedge clk); aw_valid = 1'b0; #1;
      chk("aw_to_wready", w_ready, 1);
   endtask

   task automatic send_w(input int n, input bit gap);
      int k;
      for (int i = 0; i < n; i++) begin
         if (gap) begin @(negedge clk); w_valid = 1'b0; w_last = 1'b0; end
         @(negedge clk); w_valid = 1'b1; w_last = (i == n - 1); w_data = {$urandom, $urandom}; #1;
         k = 0;
         while (!w_ready && k < 50) begin @(negedge clk); #1; k++; end
         chk("w_beat_ready", w_ready, 1);
      end
      @(negedge clk); w_valid = 1'b0; w_last = 1'b0; #1;
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [7:0] len);
      int k = 0;
      @(negedge clk); ar_id = id; ar_len = len; ar_valid = 1'b1; #1;
      while (!ar_ready && k < 100) begin @(negedge clk); #1; k++; end
      chk("ar_accept", ar_ready, 1);
      @(negedge clk); ar_valid = 1'b0; #1;
      chk("ar_to_rvalid", r_valid, 1);
   endtask

   // Collects one burst of len+1 beats with r_ready asserted pct% of cycles.
   task automatic recv_r(input logic [3:0] id, input int len, input int pct);
      int beat = 0;
      int n    = 0;
      bit stall = 1'b0;
      while (beat <= len && n < 3000) begin
         @(negedge clk); r_ready = ($urandom_range(99) < pct); #1; n++;
         if (stall) chk("r_hold_valid", r_valid, 1);
         if (r_valid) begin
            chk("r_id", r_id, id);
            chk("r_data", r_data, PAT);
            chk("r_resp", r_resp, 2'b11);
            chk("r_last", r_last, beat == len);
            stall = !r_ready;
            if (r_ready) beat++;
         end else begin
            stall = 1'b0;
         end
      end
      @(negedge clk); r_ready = 1'b0; #1;
      chk("r_beat_count", beat, len + 1);
   endtask

   typedef struct { logic [3:0] id; int len; } burst_t;
   burst_t     rq[$];
   logic [3:0] bq[$];
   int         wq[$];

   initial begin
      int aw_n = 0, ar_n = 0, b_n = 0, rb_n = 0, beat = 0, wbeat = 0, cyc = 0;
      int exp_beats = 0, got_beats = 0;
      bit aw_hs = 0, ar_hs = 0, w_hs = 0, r_pend = 0, b_pend = 0;

      rst = 1'b1;
      aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = 3'd3; aw_burst = 2'b01; aw_lock = 1'b0;
      aw_cache = '0; aw_prot = '0; aw_qos = '0; aw_region = '0; aw_atop = '0; aw_user = '0;
      aw_valid = 1'b0; w_data = '0; w_strb = '1; w_last = 1'b0; w_user = '0; w_valid = 1'b0;
      b_ready = 1'b0;
      ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = 3'd3; ar_burst = 2'b01; ar_lock = 1'b0;
      ar_cache = '0; ar_prot = '0; ar_qos = '0; ar_region = '0; ar_user = '0;
      ar_valid = 1'b0; r_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_aw_ready", aw_ready, 0);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_ar_ready", ar_ready, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_r_valid", r_valid, 0);
      chk("rst_r_last", r_last, 0);
      chk("rst_r_data", r_data, 0);
      chk("rst_b_id", b_id, 0);
      chk("rst_r_id", r_id, 0);
      chk("rst_users", {b_user, r_user}, 0);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("idle_aw_ready", aw_ready, 1);
      chk("idle_ar_ready", ar_ready, 1);

      // Single-beat write, B one cycle after w_last
      b_ready = 1'b1;
      send_aw(4'h3, 8'd0, 6'd0);
      send_w(1, 1'b0);
      chk("t1_b_valid", b_valid, 1);
      chk("t1_b_id", b_id, 4'h3);
      chk("t1_b_resp", b_resp, 2'b11);
      @(negedge clk); #1;
      chk("t1_b_done", b_valid, 0);
      chk("t1_aw_ready_again", aw_ready, 1);

      // W before AW waits; gapped 4-beat write; B held while b_ready low
      @(negedge clk); w_valid = 1'b1; w_last = 1'b0; #1;
      chk("t2_w_waits_aw", w_ready, 0);
      @(negedge clk); w_valid = 1'b0;
      b_ready = 1'b0;
      send_aw(4'h5, 8'd3, 6'd0);
      send_w(4, 1'b1);
      chk("t2_w_closed", w_ready, 0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         chk("t2_b_hold_valid", b_valid, 1);
         chk("t2_b_hold_id", b_id, 4'h5);
         chk("t2_b_hold_resp", b_resp, 2'b11);
      end
      b_ready = 1'b1;
      @(negedge clk); #1;
      chk("t2_b_done", b_valid, 0);

      // 8-beat read with r_ready toggling
      send_ar(4'h7, 8'd7);
      recv_r(4'h7, 7, 50);

      // Atomic with read response; AR arriving while it is pending waits its turn
      b_ready = 1'b0;
      send_aw(4'h9, 8'd1, 6'b100000);
      send_w(2, 1'b0);
      ar_id = 4'h3; ar_len = 8'd2; ar_valid = 1'b1; #1;
      chk("t4_ar_blocked", ar_ready, 0);
      chk("t4_b_not_yet", b_valid, 0);
      recv_r(4'h9, 1, 100);
      chk("t4_b_after_atop", b_valid, 1);
      chk("t4_b_id", b_id, 4'h9);
      chk("t4_ar_now_ready", ar_ready, 1);
      chk("t4_no_r_before_b", r_valid, 0);
      @(negedge clk); ar_valid = 1'b0; #1;
      chk("t4_ar_burst_start", r_valid, 1);
      chk("t4_b_still_held", b_valid, 1);
      recv_r(4'h3, 2, 100);
      b_ready = 1'b1;
      @(negedge clk); #1;
      chk("t4_b_done", b_valid, 0);

      // Maximum length burst
      send_ar(4'hA, 8'd255);
      recv_r(4'hA, 255, 100);

      // Reset in the middle of a read burst
      send_ar(4'h2, 8'd15);
      @(negedge clk); r_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1; ar_valid = 1'b1; ar_id = 4'h1; ar_len = 8'd0;
      @(negedge clk); #1;
      chk("t6_rst_r_valid", r_valid, 0);
      chk("t6_rst_ar_ready", ar_ready, 0);
      chk("t6_rst_aw_ready", aw_ready, 0);
      rst = 1'b0; ar_valid = 1'b0; r_ready = 1'b0;
      send_ar(4'h6, 8'd2);
      recv_r(4'h6, 2, 70);

      // Random concurrent traffic with backpressure
      while ((aw_n < N || ar_n < N || rq.size() > 0 || bq.size() > 0 || wq.size() > 0)
             && cyc < 40000) begin
         @(negedge clk); cyc++;
         if (aw_hs) aw_valid = 1'b0;
         if (ar_hs) ar_valid = 1'b0;
         if (w_hs) begin w_valid = 1'b0; w_last = 1'b0; end
         if (!aw_valid && aw_n < N && $urandom_range(3) == 0) begin
            aw_valid = 1'b1; aw_id = 4'($urandom_range(15)); aw_len = 8'($urandom_range(7));
            aw_atop = '0;
         end
         if (!ar_valid && ar_n < N && $urandom_range(3) == 0) begin
            ar_valid = 1'b1; ar_id = 4'($urandom_range(15)); ar_len = 8'($urandom_range(7));
            exp_beats += int'(ar_len) + 1;
         end
         if (!w_valid && wq.size() > 0 && $urandom_range(1) == 1) begin
            w_valid = 1'b1; w_last = (wbeat == wq[0] - 1); w_data = {$urandom, $urandom};
         end
         b_ready = ($urandom_range(2) != 0);
         r_ready = ($urandom_range(3) != 0);
         #1;
         if (r_pend) chk("rnd_r_hold", r_valid, 1);
         if (r_valid) begin
            if (rq.size() == 0) begin
               chk("rnd_r_spurious", rq.size(), 1);
            end else begin
               chk("rnd_r_id", r_id, rq[0].id);
               chk("rnd_r_data", r_data, PAT);
               chk("rnd_r_resp", r_resp, 2'b11);
               chk("rnd_r_last", r_last, beat == rq[0].len);
            end
            r_pend = !r_ready;
            if (r_ready) begin
               got_beats++;
               if (rq.size() > 0) begin
                  if (beat == rq[0].len) begin
                     void'(rq.pop_front()); beat = 0; rb_n++;
                  end else begin
                     beat++;
                  end
               end
            end
         end else begin
            r_pend = 1'b0;
         end
         if (b_pend) chk("rnd_b_hold", b_valid, 1);
         if (b_valid) begin
            if (bq.size() == 0) begin
               chk("rnd_b_spurious", bq.size(), 1);
            end else begin
               chk("rnd_b_id", b_id, bq[0]);
               chk("rnd_b_resp", b_resp, 2'b11);
            end
            b_pend = !b_ready;
            if (b_ready) begin
               b_n++;
               if (bq.size() > 0) void'(bq.pop_front());
            end
         end else begin
            b_pend = 1'b0;
         end
         aw_hs = aw_valid && aw_ready;
         ar_hs = ar_valid && ar_ready;
         w_hs  = w_valid && w_ready;
         if (aw_hs) begin bq.push_back(aw_id); wq.push_back(int'(aw_len) + 1); aw_n++; end
         if (ar_hs) begin rq.push_back('{id: ar_id, len: int'(ar_len)}); ar_n++; end
         if (w_hs) begin
            if (w_last) begin void'(wq.pop_front()); wbeat = 0; end
            else wbeat++;
         end
      end
      chk("rnd_no_hang", cyc < 40000, 1);
      chk("rnd_b_count", b_n, N);
      chk("rnd_r_bursts", rb_n, N);
      chk("rnd_r_beats", got_beats, exp_beats);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
